// File: rtl/game_stats_if.sv
// Event and display bundle between the playfield logic and game_stats.
// master: playfield/control side that raises events and reads the displays.
// slave:  game_stats itself.
interface game_stats_if;
  logic       tick;
  logic       start;
  logic       invader_hit;
  logic       player_hit;
  logic       invaders_landed;
  logic [3:0] lives;
  logic [6:0] score;
  logic       playing;
  logic       invuln;
  logic       game_over;

  modport master (
    output tick, start, invader_hit, player_hit, invaders_landed,
    input  lives, score, playing, invuln, game_over
  );

  modport slave (
    input  tick, start, invader_hit, player_hit, invaders_landed,
    output lives, score, playing, invuln, game_over
  );
endinterface

// File: rtl/game_stats.sv
// Game-state and scoring stage: play/invulnerability/game-over FSM with
// saturating lives and score that feed the segment displays directly.
// Optional bonus life per game: define GAME_STATS_EXTRA_LIFE_EN.
module game_stats #(
  parameter int unsigned START_LIVES      = 3,
  parameter int unsigned MAX_SCORE        = 99,
  parameter int unsigned INVADER_POINTS   = 1,
  parameter int unsigned INVULN_TICKS     = 100,
  parameter int unsigned EXTRA_LIFE_SCORE = 50
) (
  input logic         clk,
  input logic         arst_n,
  game_stats_if.slave bus
);

  // A zero-length invulnerability window still lasts one tick.
  localparam int unsigned LoadTicks = (INVULN_TICKS == 0) ? 1 : INVULN_TICKS;
  localparam int unsigned CntW      = $clog2(LoadTicks + 1);

  localparam logic [CntW-1:0] CntLoad   = CntW'(LoadTicks);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic [7:0]      MaxScore8 = 8'(MAX_SCORE);
  localparam logic [7:0]      Points8   = 8'(INVADER_POINTS);
  localparam logic [7:0]      Bonus8    = 8'(EXTRA_LIFE_SCORE);
  localparam logic [3:0]      LivesInit = 4'(START_LIVES);
  localparam logic [3:0]      LivesMax  = 4'd9;

  typedef enum logic [1:0] {StIdle, StPlay, StInvuln, StOver} state_e;

  state_e          state_q, state_d;
  logic [3:0]      lives_q, lives_d;
  logic [6:0]      score_q, score_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            awarded_q, awarded_d;
  logic            start_q;
  logic            playing_q, invuln_q, game_over_q;

  logic       start_pulse;
  logic [7:0] score_sum;
  logic [6:0] score_inc;
  logic       bonus;

  // Next-state: event rules applied in order score, bonus, then life loss.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    score_d   = score_q;
    cnt_d     = cnt_q;
    awarded_d = awarded_q;
    bonus     = 1'b0;

    start_pulse = bus.start & ~start_q;
    // Wide sum so a large INVADER_POINTS cannot wrap before saturation.
    score_sum   = {1'b0, score_q} + Points8;
    score_inc   = (score_sum > MaxScore8) ? MaxScore8[6:0] : score_sum[6:0];

    unique case (state_q)
      StIdle, StOver: begin
        if (start_pulse) begin
          state_d   = StPlay;
          lives_d   = LivesInit;
          score_d   = '0;
          cnt_d     = '0;
          awarded_d = 1'b0;
        end
      end
      StPlay, StInvuln: begin
        if (bus.invader_hit) score_d = score_inc;
`ifdef GAME_STATS_EXTRA_LIFE_EN
        bonus = ~awarded_q & ({1'b0, score_q} < Bonus8) & ({1'b0, score_d} >= Bonus8);
        if (bonus) awarded_d = 1'b1;
`endif
        if (bus.invaders_landed) begin
          lives_d = '0;
          cnt_d   = '0;
          state_d = StOver;
        end else if (bus.player_hit && (state_q == StPlay)) begin
          if (bonus) begin
            // Bonus and hit cancel; the hit still grants invulnerability.
            state_d = StInvuln;
            cnt_d   = CntLoad;
          end else if (lives_q > 4'd1) begin
            lives_d = lives_q - 4'd1;
            state_d = StInvuln;
            cnt_d   = CntLoad;
          end else begin
            lives_d = '0;
            state_d = StOver;
          end
        end else begin
          if (bonus && (lives_q < LivesMax)) lives_d = lives_q + 4'd1;
          if ((state_q == StInvuln) && bus.tick) begin
            cnt_d = cnt_q - CntOne;
            if (cnt_q == CntOne) state_d = StPlay;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered status flags; start_q resets high to ignore a held button.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= StIdle;
      lives_q     <= LivesInit;
      score_q     <= '0;
      cnt_q       <= '0;
      awarded_q   <= 1'b0;
      start_q     <= 1'b1;
      playing_q   <= 1'b0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      cnt_q       <= cnt_d;
      awarded_q   <= awarded_d;
      start_q     <= bus.start;
      playing_q   <= (state_d == StPlay) || (state_d == StInvuln);
      invuln_q    <= (state_d == StInvuln);
      game_over_q <= (state_d == StOver);
    end
  end

  assign bus.lives     = lives_q;
  assign bus.score     = score_q;
  assign bus.playing   = playing_q;
  assign bus.invuln    = invuln_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_game_stats.sv
// Directed bench for game_stats: reference model checked every cycle, plus
// hand-computed literal checkpoints along the test plan.
module tb_game_stats;

`ifdef GAME_STATS_EXTRA_LIFE_EN
  localparam bit ExtraEn = 1'b1;
`else
  localparam bit ExtraEn = 1'b0;
`endif

  localparam int StartLives = 3;
  localparam int MaxScore   = 99;
  localparam int Points     = 1;
  localparam int InvTicks   = 100;
  localparam int BonusAt    = 50;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  game_stats_if bus ();

  game_stats dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 play, 2 invulnerable, 3 over.
  int m_mode, m_lives, m_score, m_timer, m_old;
  bit m_prev_start, m_awarded, m_press, m_bonus, m_was_inv;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_mode = 0; m_lives = StartLives; m_score = 0; m_timer = 0;
      m_prev_start = 1'b1; m_awarded = 1'b0;
    end else begin
      m_press = bus.start && !m_prev_start;
      m_prev_start = bus.start;
      if (m_mode == 0 || m_mode == 3) begin
        if (m_press) begin
          m_mode = 1; m_lives = StartLives; m_score = 0; m_awarded = 1'b0;
        end
      end else begin
        m_was_inv = (m_mode == 2);
        m_old = m_score;
        if (bus.invader_hit) m_score = (m_score + Points > MaxScore) ? MaxScore : m_score + Points;
        m_bonus = ExtraEn && !m_awarded && m_old < BonusAt && m_score >= BonusAt;
        if (m_bonus) m_awarded = 1'b1;
        if (bus.invaders_landed) begin
          m_lives = 0; m_mode = 3;
        end else if (bus.player_hit && !m_was_inv) begin
          if (m_bonus) begin
            m_mode = 2; m_timer = InvTicks;
          end else if (m_lives > 1) begin
            m_lives = m_lives - 1; m_mode = 2; m_timer = InvTicks;
          end else begin
            m_lives = 0; m_mode = 3;
          end
        end else begin
          if (m_bonus && m_lives < 9) m_lives = m_lives + 1;
          if (m_was_inv && bus.tick) begin
            m_timer = m_timer - 1;
            if (m_timer <= 0) m_mode = 1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model lives", int'(bus.lives), m_lives);
    chk("model score", int'(bus.score), m_score);
    chk("model playing", int'(bus.playing), int'(m_mode == 1 || m_mode == 2));
    chk("model invuln", int'(bus.invuln), int'(m_mode == 2));
    chk("model game_over", int'(bus.game_over), int'(m_mode == 3));
  end

  // Hold inputs across one active edge, then return just after it.
  task automatic step(input bit t, input bit s, input bit ih, input bit ph, input bit ld);
    bus.tick = t; bus.start = s; bus.invader_hit = ih;
    bus.player_hit = ph; bus.invaders_landed = ld;
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.tick = 1'b0; bus.start = 1'b1; bus.invader_hit = 1'b0;
    bus.player_hit = 1'b0; bus.invaders_landed = 1'b0;
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    arst_n = 1'b1;

    // Start held through reset must not start a game; events in idle ignored.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("held start lives", int'(bus.lives), 3);
    chk("held start score", int'(bus.score), 0);
    chk("held start playing", int'(bus.playing), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("press playing", int'(bus.playing), 1);

    // Game 1: scoring, invulnerability, final-life hit.
    repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("five hits score", int'(bus.score), 5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("start ignored in play", int'(bus.score), 5);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("first hit lives", int'(bus.lives), 2);
    chk("first hit invuln", int'(bus.invuln), 1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("hit during invuln", int'(bus.lives), 2);
    ticks(99);
    chk("invuln at 99 ticks", int'(bus.invuln), 1);
    ticks(1);
    chk("invuln at 100 ticks", int'(bus.invuln), 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("second hit lives", int'(bus.lives), 1);
    ticks(100);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("final hit score", int'(bus.score), 6);
    chk("final hit lives", int'(bus.lives), 0);
    chk("final hit over", int'(bus.game_over), 1);
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("over holds score", int'(bus.score), 6);
    chk("over holds lives", int'(bus.lives), 0);

    // Game 2: saturation, then landing beats a same-cycle hit.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart lives", int'(bus.lives), 3);
    chk("restart score", int'(bus.score), 0);
    chk("restart playing", int'(bus.playing), 1);
    repeat (120) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("saturated score", int'(bus.score), 99);
    chk("lives after 120 hits", int'(bus.lives), ExtraEn ? 4 : 3);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("landed lives", int'(bus.lives), 0);
    chk("landed over", int'(bus.game_over), 1);

    // Game 3: bonus threshold crossing at two lives, award re-armed.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    ticks(100);
    repeat (49) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("score 49", int'(bus.score), 49);
    chk("lives at 49", int'(bus.lives), 2);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lives at 50", int'(bus.lives), ExtraEn ? 3 : 2);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lives at 51", int'(bus.lives), ExtraEn ? 3 : 2);

    // Reset mid-game while invulnerable.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    #1 arst_n = 1'b0;
    #1;
    chk("mid reset lives", int'(bus.lives), 3);
    chk("mid reset score", int'(bus.score), 0);
    chk("mid reset invuln", int'(bus.invuln), 0);
    chk("mid reset playing", int'(bus.playing), 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    arst_n = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("idle after reset", int'(bus.score), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_stats.md
Name: game_stats

Overview:
- Game-state and scoring stage that drives the `lives` and `score` nets consumed by segment_displays.
- Takes the debounced shoot level from debouncer as the start/restart control.
- Takes single-cycle collision events from the playfield logic: invader destroyed, player struck, invaders landed.
- Runs a play/invulnerability/game-over state machine and keeps lives and score saturating and display-ready.

Parameters:
- START_LIVES, 3, lives loaded at reset and at game start (1..9).
- MAX_SCORE, 99, score saturation ceiling (≤127, two display digits).
- INVADER_POINTS, 1, points added per invader_hit.
- INVULN_TICKS, 100, tick count of post-hit invulnerability (0.5 s at 200 Hz).
- EXTRA_LIFE_SCORE, 50, score threshold for the bonus life (optional feature only).

Ports:
- clk, input, 1, system clock.
- arst_n, input, 1, asynchronous active-low reset.
- tick, input, 1, single-cycle enable at 200 Hz, synchronous to clk.
- start, input, 1, debounced shoot level; its rising edge starts or restarts the game.
- invader_hit, input, 1, single-cycle pulse: player bullet destroyed an invader.
- player_hit, input, 1, single-cycle pulse: enemy bullet struck the player.
- invaders_landed, input, 1, single-cycle pulse: invaders reached the player row.
- lives, output, 4, remaining lives, 0..9.
- score, output, 7, current score, 0..MAX_SCORE.
- playing, output, 1, high in PLAY or INVULN.
- invuln, output, 1, high in INVULN.
- game_over, output, 1, high in OVER.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on arst_n. All state is clocked by clk.
- Reset values: state=IDLE, lives=START_LIVES, score=0, playing=0, invuln=0, game_over=0, invuln counter=0, start_q=1.
  - start_q resets to 1 so a button held through reset does not start a game.
- start_pulse = start & ~start_q.
- All outputs are registered and reflect an event on the clk edge after the pulse: one-cycle latency.

State machine:
- IDLE:
  - start_pulse -> PLAY.
  - Loads lives=START_LIVES and score=0.
- PLAY:
  - invader_hit: score = min(score+INVADER_POINTS, MAX_SCORE). Computed at 8 bits, then saturated.
  - player_hit with lives>1: lives-1, load counter=INVULN_TICKS, -> INVULN.
  - player_hit with lives==1: lives=0, -> OVER.
- INVULN:
  - player_hit ignored.
  - invader_hit scored as in PLAY.
  - Counter decrements on each tick. When a tick arrives with counter==1, -> PLAY.
  - INVULN_TICKS=0 is treated as 1.
- Any playing state:
  - invaders_landed: lives=0, -> OVER.
  - invaders_landed has priority over player_hit in the same cycle.
- OVER:
  - Outputs hold their final values.
  - start_pulse: lives=START_LIVES, score=0, -> PLAY directly.

Event rules:
- invader_hit and player_hit in the same cycle: both apply. Score updates, then the life rule applies.
- A final-life hit still credits the same-cycle invader_hit.
- invader_hit, player_hit and invaders_landed are ignored in IDLE and OVER.
- start_pulse is ignored in PLAY and INVULN.
- lives never underflows below 0 and never exceeds 9.
- Score never wraps.
- Reset asserted mid-game returns immediately to the reset values, regardless of state or counter.

Optional Feature:
- Macro: GAME_STATS_EXTRA_LIFE_EN.
- When defined:
  - Bonus life awarded once per game, on the cycle score first goes from <EXTRA_LIFE_SCORE to ≥EXTRA_LIFE_SCORE.
  - Award is lives+1, saturating at 9.
  - A one-bit "awarded" flag clears at reset and at each game start.
  - If the award coincides with a player_hit, the net lives change is 0. The player still enters INVULN.
- When undefined:
  - No bonus logic is present; lives only decrease during a game.

Test Plan:
1. Reset with start held high, then release and press start -> lives=3, score=0 until the press edge; after the edge, playing=1.
2. In PLAY, 5 invader_hit pulses -> score=5. Force 120 hits -> score saturates at 99 and never wraps.
3. player_hit at lives=3 -> lives=2, invuln=1.
   - A second player_hit during INVULN -> lives stays 2.
   - After 100 ticks -> invuln=0.
4. Lives=1: invader_hit and player_hit in the same cycle -> score+1, lives=0, game_over=1. Further hits leave all outputs unchanged.
5. invaders_landed together with player_hit at lives=3 -> lives=0, game_over=1. Then start edge -> lives=3, score=0, playing=1.
6. With GAME_STATS_EXTRA_LIFE_EN, score 49→50 at lives=2 -> lives=3, awarded once. Dropping to and recrossing 50 in the same game is impossible; the next game re-arms the award.
